// File: rtl/button_event_pkg.sv
// Shared definitions for the button event detector: state encodings,
// the FSM state type and a small helper for sizing the cycle counter.
package button_event_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;
    localparam logic [1:0] ST_LONG  = 2'd3;

    typedef enum logic [1:0] {
        INIT  = ST_INIT,
        IDLE  = ST_IDLE,
        PRESS = ST_PRESS,
        LONG  = ST_LONG
    } state_t;

    // Larger of two integers, used to size the shared press/repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event.sv
// Button event detector. Turns a debounced, synchronous button level into
// one-cycle press / release / long-press / auto-repeat pulses, a held level
// and a wrapping count of accepted presses.
// The release and repeat pulses are named release_evt and repeat_evt because
// "release" and "repeat" are reserved words in SystemVerilog.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CNT   = 50_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       press,
    output logic       release_evt,
    output logic       long_press,
    output logic       repeat_evt,
    output logic       held,
    output logic [7:0] press_cnt
);

    localparam int CNT_W = $clog2(max_int(LONG_CNT, REPEAT_CNT));
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    // Next-state logic: a button held through reset waits in INIT until it is
    // released; a release always beats a long-press or repeat on the same edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        press_cnt_d = press_cnt_q;
        case (state_q)
            INIT: begin
                if (!in) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (in) begin
                    state_d     = PRESS;
                    cnt_d       = '0;
                    press_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                end
            end
            PRESS: begin
                if (!in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LONG: begin
                if (!in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESS) || (state_d == LONG);
    end

    // State, counter and registered outputs; reset returns to INIT silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press       = press_q;
    assign release_evt = release_q;
    assign long_press  = long_q;
    assign repeat_evt  = repeat_q;
    assign held        = held_q;
    assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_button_event.sv
// Testbench for button_event with LONG_CNT=8, REPEAT_CNT=4. A reference model
// based on how long the button has been held predicts every output cycle.
module tb_button_event;

    localparam int LONG = 8;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in;
    logic       press, release_evt, long_press, repeat_evt, held;
    logic [7:0] press_cnt;

    int total = 0;
    int bad   = 0;

    bit   m_armed;
    bit   m_pressed;
    int   m_k;
    int   m_cnt;
    logic [12:0] exp_v;
    logic [12:0] obs_v;

    button_event #(.LONG_CNT(LONG), .REPEAT_CNT(REP)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .press      (press),
        .release_evt(release_evt),
        .long_press (long_press),
        .repeat_evt (repeat_evt),
        .held       (held),
        .press_cnt  (press_cnt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Drives one cycle of stimulus, advances the model and samples the DUT
    // just after the edge.
    task automatic tick(input logic in_v, input logic rst_v);
        logic e_press, e_rel, e_long, e_rep;
        in    = in_v;
        reset = rst_v;
        @(posedge clk);
        #1;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (rst_v) begin
            m_armed   = 1'b0;
            m_pressed = 1'b0;
            m_k       = 0;
            m_cnt     = 0;
        end else if (!m_armed) begin
            if (!in_v) m_armed = 1'b1;
        end else if (!m_pressed) begin
            if (in_v) begin
                m_pressed = 1'b1;
                m_k       = 0;
                m_cnt     = (m_cnt + 1) % 256;
                e_press   = 1'b1;
            end
        end else if (!in_v) begin
            m_pressed = 1'b0;
            e_rel     = 1'b1;
        end else begin
            m_k = m_k + 1;
            if (m_k == LONG) e_long = 1'b1;
            else if (m_k > LONG && ((m_k - LONG) % REP) == 0) e_rep = 1'b1;
        end
        exp_v = {e_press, e_rel, e_long, e_rep, m_pressed, 8'(m_cnt)};
        obs_v = {press, release_evt, long_press, repeat_evt, held, press_cnt};
    endtask

    // Reset clears every output and parks the FSM.
    task automatic test_reset();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        total++;
        if (obs_v !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=%h", obs_v, 13'd0);
        end
        tick(1'b0, 1'b0);
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%h want=%h", obs_v, exp_v);
        end
    endtask

    // Three-cycle press: press at offset 0, release at offset 3, no long-press.
    task automatic test_short_press();
        logic pat [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int press_at = -1;
        int rel_at = -1;
        int nl = 0;
        for (int i = 0; i < 5; i++) begin
            tick(pat[i], 1'b0);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL short_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (press && press_at < 0) press_at = i;
            if (release_evt && rel_at < 0) rel_at = i;
            if (long_press) nl++;
        end
        total++;
        if (press_at !== 0 || rel_at !== 3 || nl !== 0) begin
            bad++;
            $display("[TB] FAIL short_timing got press@%0d rel@%0d long=%0d want 0/3/0", press_at, rel_at, nl);
        end
        total++;
        if (press_cnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL short_count got=%0d want=1", press_cnt);
        end
    endtask

    // Held 20 cycles: long-press at offset 8, repeats at 12 and 16, release at 20.
    task automatic test_long_repeat();
        int long_at = -1;
        int rel_at = -1;
        int reps[$];
        for (int i = 0; i < 22; i++) begin
            tick(i < 20, 1'b0);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL long_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (long_press) long_at = i;
            if (repeat_evt) reps.push_back(i);
            if (release_evt) rel_at = i;
        end
        total++;
        if (long_at !== 8 || rel_at !== 20) begin
            bad++;
            $display("[TB] FAIL long_timing got long@%0d rel@%0d want 8/20", long_at, rel_at);
        end
        total++;
        if (reps.size() != 2 || reps[0] != 12 || reps[1] != 16) begin
            bad++;
            $display("[TB] FAIL repeat_timing got n=%0d want repeats at 12,16", reps.size());
        end
    endtask

    // Release on the long-press edge suppresses the long-press pulse.
    task automatic test_release_wins();
        int rel_at = -1;
        int nl = 0;
        for (int i = 0; i < 10; i++) begin
            tick(i < LONG, 1'b0);
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL relwin_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (release_evt) rel_at = i;
            if (long_press) nl++;
        end
        total++;
        if (rel_at !== LONG || nl !== 0) begin
            bad++;
            $display("[TB] FAIL relwin_timing got rel@%0d long=%0d want %0d/0", rel_at, nl, LONG);
        end
    endtask

    // Button held through reset is ignored until it has been released.
    task automatic test_reset_while_held();
        int np = 0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            if (press || held) np++;
        end
        total++;
        if (np !== 0) begin
            bad++;
            $display("[TB] FAIL held_reset_ignored got=%0d want=0", np);
        end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        total++;
        if (press !== 1'b1 || press_cnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL held_reset_press got press=%b cnt=%0d want 1/1", press, press_cnt);
        end
        tick(1'b0, 1'b0);
        total++;
        if (obs_v !== exp_v) begin
            bad++;
            $display("[TB] FAIL held_reset_model got=%h want=%h", obs_v, exp_v);
        end
    endtask

    // Reset during LONG clears outputs at once and never produces a release.
    task automatic test_reset_in_long();
        int nr = 0;
        for (int i = 0; i < LONG + 2; i++) tick(1'b1, 1'b0);
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("[TB] FAIL inlong_held got=%b want=1", held);
        end
        tick(1'b1, 1'b1);
        total++;
        if (obs_v !== 13'd0) begin
            bad++;
            $display("[TB] FAIL inlong_reset got=%h want=%h", obs_v, 13'd0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(i < 3, 1'b0);
            if (release_evt) nr++;
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL inlong_model cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
        total++;
        if (nr !== 0) begin
            bad++;
            $display("[TB] FAIL inlong_no_release got=%0d want=0", nr);
        end
    endtask

    // 256 press/release pairs wrap the press counter back to zero.
    task automatic test_wrap();
        int np = 0;
        int nr = 0;
        int nbad = 0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 1'b0);
            if (press) np++;
            if (obs_v !== exp_v) nbad++;
            tick(1'b0, 1'b0);
            if (release_evt) nr++;
            if (obs_v !== exp_v) nbad++;
        end
        total++;
        if (np !== 256 || nr !== 256 || press_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL wrap got press=%0d rel=%0d cnt=%0d want 256/256/0", np, nr, press_cnt);
        end
        total++;
        if (nbad !== 0) begin
            bad++;
            $display("[TB] FAIL wrap_model got=%0d mismatching cycles want=0", nbad);
        end
    endtask

    // Random hold/release runs with occasional resets against the model.
    task automatic test_random();
        logic lvl;
        int run;
        int cyc = 0;
        lvl = 1'b0;
        while (cyc < 3000) begin
            lvl = ~lvl;
            run = $urandom_range(1, 3 * (LONG + REP));
            for (int j = 0; j < run; j++) begin
                tick(lvl, ($urandom_range(0, 199) == 0));
                cyc++;
                total++;
                if (obs_v !== exp_v) begin
                    bad++;
                    $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
                end
                total++;
                if ($countones(obs_v[12:9]) > 1) begin
                    bad++;
                    $display("[TB] FAIL random_onehot cyc=%0d got=%b want at most one", cyc, obs_v[12:9]);
                end
            end
        end
    endtask

    // Runs the scenarios in order and prints the summary.
    initial begin
        reset     = 1'b1;
        in        = 1'b0;
        m_armed   = 1'b0;
        m_pressed = 1'b0;
        m_k       = 0;
        m_cnt     = 0;
        exp_v     = '0;
        obs_v     = '0;
        test_reset();
        test_short_press();
        test_long_repeat();
        test_release_wins();
        test_reset_while_held();
        test_reset_in_long();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The block SHALL have parameter LONG_CNT, default 50_000_000, meaning cycles a press must be held before a long-press event (minimum 2).
REQ-002 The block SHALL have parameter REPEAT_CNT, default 10_000_000, meaning cycles between auto-repeat events once long-press is reached (minimum 2).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port in, input, 1, meaning the debounced button level, already synchronous to clk, 1 = pressed.
REQ-006 The block SHALL have port press, output, 1, meaning a one-cycle pulse on each accepted press.
REQ-007 The block SHALL have port release, output, 1, meaning a one-cycle pulse on each release of an accepted press.
REQ-008 The block SHALL have port long_press, output, 1, meaning a one-cycle pulse when a press reaches LONG_CNT cycles.
REQ-009 The block SHALL have port repeat, output, 1, meaning a one-cycle pulse every REPEAT_CNT cycles after long_press while still held.
REQ-010 The block SHALL have port held, output, 1, meaning the level is high while the FSM is in PRESS or LONG.
REQ-011 The block SHALL have port press_cnt, output, 8, meaning the count of accepted presses, wrapping from 255 to 0.

Function
REQ-012 The FSM SHALL have four states (INIT, IDLE, PRESS, LONG) and one cycle counter cnt of width $clog2(max(LONG_CNT,REPEAT_CNT)).
REQ-013 In INIT: in=0 -> IDLE; in=1 -> stay in INIT with no events, so a button held through reset is ignored until it is released.
REQ-014 In IDLE with in=1 at edge t0: go to PRESS, cnt<=0, press=1 for the cycle after t0 only, press_cnt<=press_cnt+1.
REQ-015 In PRESS with in=1: if cnt==LONG_CNT-1, go to LONG, cnt<=0, long_press=1 for one cycle (visible after edge t0+LONG_CNT); otherwise cnt<=cnt+1.
REQ-016 In LONG with in=1: if cnt==REPEAT_CNT-1, repeat=1 for one cycle and cnt<=0; otherwise cnt<=cnt+1. The first repeat is visible after edge t0+LONG_CNT+REPEAT_CNT.
REQ-017 In PRESS or LONG with in=0: go to IDLE, cnt<=0, release=1 for one cycle.
REQ-018 If release coincides with the edge on which long_press or repeat would fire, release SHALL win and the other pulse SHALL NOT fire.
REQ-019 All pulse outputs SHALL be registered with 1-cycle latency from the sampling edge, and at most one of press/release/long_press/repeat SHALL be high in any cycle.
REQ-020 held SHALL be high from the cycle press is high through the cycle before release is high.
REQ-021 press_cnt SHALL wrap modulo 256 and SHALL NOT saturate.

Reset
REQ-022 When reset is high at an edge: state<=INIT, cnt<=0, press/release/long_press/repeat/held<=0, press_cnt<=0; reset has priority over all other transitions.
REQ-023 A reset asserted mid-press SHALL produce no release pulse, and the press SHALL be ignored until in returns to 0 (per REQ-013).

Structure
REQ-024 The state encodings (INIT=0, IDLE=1, PRESS=2, LONG=3) SHALL be localparams in the shared package button_event_pkg.
REQ-025 No sub-module SHALL be used; the counter and FSM SHALL be a single module, instantiated directly downstream of the debouncer.

Verification (LONG_CNT=8, REPEAT_CNT=4)
REQ-026 in 0->1 at edge 10, held 3 cycles, then 0 -> press high in cycle 11, release high in cycle 14, no long_press, press_cnt=1.
REQ-027 in held 20 cycles from edge 10 -> long_press in cycle 19, repeat in cycles 23 and 27, release one cycle after in falls.
REQ-028 in drops exactly at edge 18 (the edge long_press would fire) -> release high in cycle 19, long_press never asserts.
REQ-029 in=1 during and after a reset deassert -> no press until in goes 0 then 1; the subsequent press then yields press_cnt=1.
REQ-030 Reset pulsed while in LONG -> all outputs 0 next cycle, no release pulse, state INIT.
REQ-031 256 press/release cycles -> press_cnt wraps to 0, with exactly one press and one release pulse per cycle pair.
